pipelined_barrel_shifter: RTL

- Parametrised, pipelined log-shifter for the ALU.
- Supports four modes: logical left, logical right, arithmetic right, rotate left.
- Uses valid/ready handshakes on input and output, with full backpressure and a throughput of one operation per clock.
- Sits between operand decode and the ALU result mux; an optional tag travels with each operation so results can be matched.

---
 rtl/pipelined_barrel_shifter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: pipelined log-shifter (SLL/SRL/SRA/ROL) with valid/ready
// handshakes, full backpressure and a sideband tag that travels with each operation.
// Optional result flags (out_zero, out_lsb_lost) when PIPELINED_BARREL_SHIFTER_FLAGS_EN is defined.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned REG_EVERY = 2,
  parameter int unsigned TAG_W     = 4,
  localparam int unsigned SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_lsb_lost
`endif
);

  localparam int unsigned P = (SHW + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One mux stage: shift by a fixed power of two with the mode's fill rule.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d, input int amt,
                                                   input logic [1:0] op, input logic sign);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = d << amt;
      OP_SRL:  r = d >> amt;
      OP_SRA:  r = (d >> amt) | (sign ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}});
      default: r = (d << amt) | (d >> (int'(WIDTH) - amt));
    endcase
    return r;
  endfunction

  // Any 1 bit pushed out of the word by this stage; rotation never loses bits.
  function automatic logic lost_stage(input logic [WIDTH-1:0] d, input int amt,
                                      input logic [1:0] op);
    logic r;
    case (op)
      OP_SLL:         r = |(d >> (int'(WIDTH) - amt));
      OP_SRL, OP_SRA: r = |(d << (int'(WIDTH) - amt));
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] data_q  [P];
  logic [SHW-1:0]   shamt_q [P];
  logic [1:0]       op_q    [P];
  logic [TAG_W-1:0] tag_q   [P];
  logic             sign_q  [P];
  logic [P-1:0]     vld_q;

  logic [WIDTH-1:0] src_data  [P];
  logic [SHW-1:0]   src_shamt [P];
  logic [1:0]       src_op    [P];
  logic [TAG_W-1:0] src_tag   [P];
  logic             src_sign  [P];
  logic [P-1:0]     src_vld;
  logic [WIDTH-1:0] nxt_data  [P];
  logic [P-1:0]     adv;

`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  logic [P-1:0] lost_q;
  logic [P-1:0] src_lost;
  logic [P-1:0] nxt_lost;
  logic         zero_q;
`endif

  // Advance chain: a slot moves when empty or when its downstream slot moves.
  always_comb begin
    adv        = '0;
    adv[P-1]   = ~vld_q[P-1] | out_ready;
    for (int s = int'(P) - 2; s >= 0; s--) begin
      adv[s] = ~vld_q[s] | adv[s+1];
    end
  end

  // Slot inputs: slot 0 takes the operand port, later slots take the previous register.
  always_comb begin
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
    src_sign[0]  = in_data[WIDTH-1];
    src_vld      = '0;
    src_vld[0]   = in_valid;
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    src_lost     = '0;
`endif
    for (int s = 1; s < int'(P); s++) begin
      src_data[s]  = data_q[s-1];
      src_shamt[s] = shamt_q[s-1];
      src_op[s]    = op_q[s-1];
      src_tag[s]   = tag_q[s-1];
      src_sign[s]  = sign_q[s-1];
      src_vld[s]   = vld_q[s-1];
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      src_lost[s]  = lost_q[s-1];
`endif
    end
  end

  // Mux stages: stage k belongs to slot k / REG_EVERY and shifts by 2^k when shamt[k] is set.
  always_comb begin
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
    nxt_lost = '0;
`endif
    for (int s = 0; s < int'(P); s++) begin
      nxt_data[s] = src_data[s];
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      nxt_lost[s] = src_lost[s];
`endif
      for (int k = 0; k < int'(SHW); k++) begin
        if ((k / int'(REG_EVERY)) == s && src_shamt[s][k]) begin
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
          nxt_lost[s] = nxt_lost[s] | lost_stage(nxt_data[s], 1 << k, src_op[s]);
`endif
          nxt_data[s] = shift_stage(nxt_data[s], 1 << k, src_op[s], src_sign[s]);
        end
      end
    end
  end

  // Slot registers: payload loads only when the slot advances with a valid operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int s = 0; s < int'(P); s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        op_q[s]    <= '0;
        tag_q[s]   <= '0;
        sign_q[s]  <= 1'b0;
      end
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      lost_q <= '0;
      zero_q <= 1'b0;
`endif
    end else begin
      for (int s = 0; s < int'(P); s++) begin
        if (adv[s]) begin
          vld_q[s] <= src_vld[s];
          if (src_vld[s]) begin
            data_q[s]  <= nxt_data[s];
            shamt_q[s] <= src_shamt[s];
            op_q[s]    <= src_op[s];
            tag_q[s]   <= src_tag[s];
            sign_q[s]  <= src_sign[s];
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
            lost_q[s]  <= nxt_lost[s];
`endif
          end
        end
      end
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
      if (adv[P-1] && src_vld[P-1]) begin
        zero_q <= (nxt_data[P-1] == '0);
      end
`endif
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[P-1];
  assign out_data  = data_q[P-1];
  assign out_tag   = tag_q[P-1];
`ifdef PIPELINED_BARREL_SHIFTER_FLAGS_EN
  assign out_zero     = zero_q;
  assign out_lsb_lost = lost_q[P-1];
`endif

endmodule
